// File: rtl/multi_timer.sv
// multi_timer: a bank of independent up-counting timer channels that share
// one free-running prescaler.
//
// Each channel counts prescaler ticks from 0 up to its target. When a tick
// arrives with count >= target, the channel has reached its target. What it
// does next depends on its mode:
//   HOLD     (00, and 11) : stop in DONE; count is held; hit stays high.
//   ONESHOT  (01)         : stop in DONE; count is held; hit is high for one cycle.
//   PERIODIC (10)         : stay in RUN; count returns to 0; hit is high for one cycle.
// hit_pulse is high for exactly one cycle on every target event, in all modes.
// A channel leaves DONE only through reset, clear[i], or en[i] going low.
//
// Ports
//   clk        in   rising-edge clock for all state
//   reset      in   synchronous, active-high
//   prescale   in   [PRE_WIDTH]         one tick every prescale+1 cycles
//   en         in   [CHANNELS]          per-channel run enable (level)
//   clear      in   [CHANNELS]          per-channel synchronous clear
//   mode       in   [2*CHANNELS]        channel i at [2i+1:2i]
//   target     in   [WIDTH*CHANNELS]    channel i at [WIDTH*i +: WIDTH]
//   count      out  [WIDTH*CHANNELS]    registered count, same packing as target
//   hit        out  [CHANNELS]          registered status level
//   hit_pulse  out  [CHANNELS]          registered one-cycle target-event strobe
//   state_dbg  out  [2*CHANNELS]        channel FSM state, channel i at [2i+1:2i]
//                                       (0 IDLE, 1 RUN, 2 DONE)

module multi_timer #(
   parameter int WIDTH     = 8,
   parameter int CHANNELS  = 4,
   parameter int PRE_WIDTH = 4
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [PRE_WIDTH-1:0]      prescale,
   input  logic [CHANNELS-1:0]       en,
   input  logic [CHANNELS-1:0]       clear,
   input  logic [2*CHANNELS-1:0]     mode,
   input  logic [WIDTH*CHANNELS-1:0] target,
   output logic [WIDTH*CHANNELS-1:0] count,
   output logic [CHANNELS-1:0]       hit,
   output logic [CHANNELS-1:0]       hit_pulse,
   output logic [2*CHANNELS-1:0]     state_dbg
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   localparam logic [1:0] MODE_HOLD     = 2'b00;
   localparam logic [1:0] MODE_ONESHOT  = 2'b01;
   localparam logic [1:0] MODE_PERIODIC = 2'b10;
   localparam logic [1:0] MODE_HOLD_ALT = 2'b11;

   // ---------------------------------------------------------------
   // Shared prescaler. The >= comparison means that lowering prescale
   // below the current pre_cnt produces a tick on the next edge. The
   // counter therefore never has to wrap around 2^PRE_WIDTH to catch up.
   // ---------------------------------------------------------------
   logic [PRE_WIDTH-1:0] pre_cnt_q, pre_cnt_d;
   logic                 tick;

   always_comb begin
      tick      = (pre_cnt_q >= prescale);
      pre_cnt_d = pre_cnt_q + PRE_WIDTH'(1);
      if (tick) begin
         pre_cnt_d = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         pre_cnt_q <= '0;
      end else begin
         pre_cnt_q <= pre_cnt_d;
      end
   end

   // ---------------------------------------------------------------
   // Timer channels
   // ---------------------------------------------------------------
   for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
      state_t           state_q, state_d;
      logic [WIDTH-1:0] count_q, count_d;
      logic             hit_q, hit_d;
      logic             pulse_q, pulse_d;
      logic [WIDTH-1:0] tgt;
      logic [1:0]       md;
      logic             md_hold;

      assign tgt     = target[WIDTH*i +: WIDTH];
      assign md      = mode[2*i +: 2];
      assign md_hold = (md == MODE_HOLD) || (md == MODE_HOLD_ALT);

      always_comb begin
         state_d = state_q;
         count_d = count_q;
         // hit and hit_pulse are cleared by default. Only a target event,
         // or a HOLD channel sitting in DONE, drives them high.
         hit_d   = 1'b0;
         pulse_d = 1'b0;

         if (clear[i] || !en[i]) begin
            state_d = ST_IDLE;
            count_d = '0;
         end else begin
            case (state_q)
               ST_IDLE: begin
                  // Start on the enable edge whether or not a tick occurs.
                  state_d = ST_RUN;
                  count_d = '0;
               end
               ST_RUN: begin
                  if (tick) begin
                     if (count_q < tgt) begin
                        count_d = count_q + WIDTH'(1);
                     end else begin
                        // Using >= means a target lowered below count
                        // mid-run still fires, so count never wraps.
                        pulse_d = 1'b1;
                        hit_d   = 1'b1;
                        if (md == MODE_PERIODIC) begin
                           count_d = '0;
                        end else begin
                           state_d = ST_DONE;
                        end
                     end
                  end
               end
               ST_DONE: begin
                  // HOLD keeps hit high while in DONE. ONESHOT lets hit
                  // drop after the event cycle. A mode change here never
                  // leaves DONE.
                  hit_d = hit_q && md_hold;
               end
               default: begin
                  state_d = ST_IDLE;
                  count_d = '0;
               end
            endcase
         end
      end

      always_ff @(posedge clk) begin
         if (reset) begin
            state_q <= ST_IDLE;
            count_q <= '0;
            hit_q   <= 1'b0;
            pulse_q <= 1'b0;
         end else begin
            state_q <= state_d;
            count_q <= count_d;
            hit_q   <= hit_d;
            pulse_q <= pulse_d;
         end
      end

      assign count[WIDTH*i +: WIDTH] = count_q;
      assign hit[i]                  = hit_q;
      assign hit_pulse[i]            = pulse_q;
      assign state_dbg[2*i +: 2]     = state_q;
   end

   // MODE_ONESHOT is named for readability; ONESHOT behaviour is the
   // non-PERIODIC, non-HOLD path above.
   logic unused_mode_name;
   assign unused_mode_name = ^MODE_ONESHOT;

endmodule

// File: tb/tb_multi_timer.sv
module tb_multi_timer;

   localparam int W  = 4;
   localparam int CH = 4;
   localparam int PW = 4;
   localparam int OW = W*CH + 2*CH;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic              reset    = 1'b1;
   logic [PW-1:0]     prescale = '0;
   logic [CH-1:0]     en       = '0;
   logic [CH-1:0]     clear    = '0;
   logic [2*CH-1:0]   mode     = '0;
   logic [W*CH-1:0]   target   = '0;
   logic [W*CH-1:0]   count;
   logic [CH-1:0]     hit;
   logic [CH-1:0]     hit_pulse;
   logic [2*CH-1:0]   state_dbg;

   multi_timer #(.WIDTH(W), .CHANNELS(CH), .PRE_WIDTH(PW)) dut (
      .clk       (clk),
      .reset     (reset),
      .prescale  (prescale),
      .en        (en),
      .clear     (clear),
      .mode      (mode),
      .target    (target),
      .count     (count),
      .hit       (hit),
      .hit_pulse (hit_pulse),
      .state_dbg (state_dbg)
   );

   int n_vec = 0;
   int n_err = 0;
   int cyc   = 0;

   // ---------------- reference model ----------------
   // phase: 0 stopped, 1 counting, 2 finished
   int              m_pc;
   int              m_phase [CH];
   int              m_cnt   [CH];
   bit              m_hit   [CH];
   bit              m_pulse [CH];
   logic [OW-1:0]   exp_q[$];
   logic [OW-1:0]   model_out;

   task automatic model_step();
      logic [OW-1:0] o;
      bit tk;
      if (reset) begin
         m_pc = 0;
         for (int i = 0; i < CH; i++) begin
            m_phase[i] = 0; m_cnt[i] = 0; m_hit[i] = 0; m_pulse[i] = 0;
         end
      end else begin
         tk   = (m_pc >= int'(prescale));
         m_pc = tk ? 0 : m_pc + 1;
         for (int i = 0; i < CH; i++) begin
            int t;
            int md;
            t  = int'(target[W*i +: W]);
            md = int'(mode[2*i +: 2]);
            m_pulse[i] = 0;
            if (clear[i] || !en[i]) begin
               m_phase[i] = 0; m_cnt[i] = 0; m_hit[i] = 0;
            end else if (m_phase[i] == 0) begin
               m_phase[i] = 1; m_cnt[i] = 0; m_hit[i] = 0;
            end else if (m_phase[i] == 1) begin
               m_hit[i] = 0;
               if (tk) begin
                  if (m_cnt[i] < t) m_cnt[i] = m_cnt[i] + 1;
                  else begin
                     m_pulse[i] = 1; m_hit[i] = 1;
                     if (md == 2) m_cnt[i] = 0;
                     else         m_phase[i] = 2;
                  end
               end
            end else begin
               m_hit[i] = m_hit[i] && (md == 0 || md == 3);
            end
         end
      end
      for (int i = 0; i < CH; i++) begin
         o[2*CH + W*i +: W] = W'(m_cnt[i]);
         o[CH + i]          = m_hit[i];
         o[i]               = m_pulse[i];
      end
      exp_q.push_back(o);
   endtask

   // ---------------- driver tasks ----------------
   task automatic step();
      model_step();
      @(posedge clk);
      #1;
      cyc++;
      model_out = exp_q.pop_front();
   endtask

   task automatic do_reset();
      reset = 1'b1; en = '0; clear = '0;
      step();
      reset = 1'b0;
      cyc   = 0;
   endtask

   // ---------------- scoreboard compare ----------------
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s (edge %0d): got %0h expected %0h", name, cyc - 1, act, exp);
      end
   endtask

   // ---------------- vector table ----------------
   typedef struct {
      logic          rst;
      logic [CH-1:0] en;
      logic [CH-1:0] clr;
      logic [7:0]    md;
      logic [15:0]   tg;
      logic [PW-1:0] pre;
      logic [15:0]   e_count;
      logic [3:0]    e_hit;
      logic [3:0]    e_pulse;
   } vec_t;

   vec_t tbl[12];

   function automatic vec_t mk(input logic r, input logic [3:0] e, input logic [15:0] ec,
                               input logic [3:0] eh, input logic [3:0] ep);
      vec_t v;
      v.rst = r; v.en = e; v.clr = '0; v.md = 8'h0A; v.tg = 16'h0030; v.pre = '0;
      v.e_count = ec; v.e_hit = eh; v.e_pulse = ep;
      return v;
   endfunction

   // ---------------- oneshot helper ----------------
   // Ticks occur on edges whose index since reset release is 2 mod 3
   // (prescale = 2). The event comes on the third tick after the start edge.
   task automatic run_oneshot(input string name, input int s);
      int npulse;
      int pulse_at;
      int first_tick;
      npulse = 0; pulse_at = -1;
      for (int k = 0; k < 24; k++) begin
         step();
         if (hit_pulse[2]) begin
            npulse++;
            pulse_at = cyc - 1;
         end
      end
      first_tick = s + 1;
      while (first_tick % 3 != 2) first_tick++;
      check({name, "_npulse"},   32'(npulse),   32'd1);
      check({name, "_pulse_at"}, 32'(pulse_at), 32'(first_tick + 6));
      check({name, "_count"},    32'(count[11:8]), 32'd2);
      check({name, "_hit_low"},  32'(hit[2]),   32'd0);
   endtask

   int s;

   initial begin
      // ---- table: reset, then ch0 PERIODIC tgt 0, ch1 PERIODIC tgt 3 ----
      tbl[0]  = mk(1, 4'h0, 16'h0000, 4'h0, 4'h0);
      tbl[1]  = mk(1, 4'hF, 16'h0000, 4'h0, 4'h0);
      tbl[2]  = mk(0, 4'h3, 16'h0000, 4'h0, 4'h0);
      tbl[3]  = mk(0, 4'h3, 16'h0010, 4'h1, 4'h1);
      tbl[4]  = mk(0, 4'h3, 16'h0020, 4'h1, 4'h1);
      tbl[5]  = mk(0, 4'h3, 16'h0030, 4'h1, 4'h1);
      tbl[6]  = mk(0, 4'h3, 16'h0000, 4'h3, 4'h3);
      tbl[7]  = mk(0, 4'h3, 16'h0010, 4'h1, 4'h1);
      tbl[8]  = mk(0, 4'h3, 16'h0020, 4'h1, 4'h1);
      tbl[9]  = mk(0, 4'h3, 16'h0030, 4'h1, 4'h1);
      tbl[10] = mk(0, 4'h3, 16'h0000, 4'h3, 4'h3);
      tbl[11] = mk(0, 4'h0, 16'h0000, 4'h0, 4'h0);

      for (int v = 0; v < 12; v++) begin
         reset = tbl[v].rst; en = tbl[v].en; clear = tbl[v].clr;
         mode = tbl[v].md; target = tbl[v].tg; prescale = tbl[v].pre;
         step();
         check($sformatf("tbl%0d_count", v), 32'(count),     32'(tbl[v].e_count));
         check($sformatf("tbl%0d_hit", v),   32'(hit),       32'(tbl[v].e_hit));
         check($sformatf("tbl%0d_pulse", v), 32'(hit_pulse), 32'(tbl[v].e_pulse));
         if (v == 0) check("reset_state_idle", 32'(state_dbg), 32'd0);
      end

      // ---- HOLD, target 15, prescale 0 on ch0 ----
      do_reset();
      prescale = '0; mode = 8'h00; target = 16'h000F; en = 4'b0001;
      step();
      check("hold_start_count", 32'(count[3:0]), 32'd0);
      for (int k = 1; k <= 15; k++) begin
         step();
         check($sformatf("hold_count_%0d", k), 32'({hit[0], count[3:0]}), 32'(k));
      end
      step();
      check("hold_event", 32'({hit_pulse[0], hit[0], count[3:0]}), 32'h3F);
      step();
      check("hold_after", 32'({hit_pulse[0], hit[0], count[3:0]}), 32'h1F);
      repeat (3) step();
      check("hold_stays", 32'({hit_pulse[0], hit[0], count[3:0]}), 32'h1F);
      en = 4'b0000;
      step();
      check("hold_en_low", 32'({hit[0], count[3:0]}), 32'h00);

      // ---- ONESHOT, target 2, prescale 2 on ch2, then re-arm ----
      do_reset();
      prescale = 4'd2; mode = 8'h10; target = 16'h0200; en = 4'b0100;
      s = cyc;
      run_oneshot("oneshot1", s);
      en = 4'b0000;
      step();
      check("oneshot_disarm_count", 32'(count[11:8]), 32'd0);
      en = 4'b0100;
      s = cyc;
      run_oneshot("oneshot2", s);

      // ---- PERIODIC target lowered mid-run on ch3 ----
      do_reset();
      prescale = '0; mode = 8'h80; target = 16'hA000; en = 4'b1000;
      step();
      repeat (7) step();
      check("per_lower_pre", 32'(count[15:12]), 32'd7);
      target = 16'h4000;
      step();
      check("per_lower_event", 32'({hit_pulse[3], count[15:12]}), 32'h10);
      for (int j = 1; j <= 10; j++) begin
         step();
         check($sformatf("per_lower_j%0d", j), 32'({hit_pulse[3], count[15:12]}),
               (j % 5 == 0) ? 32'h10 : 32'(j % 5));
      end

      // ---- clear mid-run, then reset mid-run ----
      do_reset();
      prescale = '0; mode = 8'h00; target = 16'hFF0F; en = 4'b1111;
      step();
      repeat (5) step();
      check("clr_pre_count", 32'(count), 32'h5505);
      check("clr_pre_hit",   32'(hit),   32'h2);
      clear = 4'b0001;
      step();
      check("clr_edge", 32'(count), 32'h6600);
      clear = 4'b0000;
      step();
      check("clr_restart", 32'(count), 32'h7700);
      step();
      check("clr_counting", 32'(count), 32'h8801);
      reset = 1'b1;
      step();
      check("rst_mid_count", 32'(count), 32'h0);
      check("rst_mid_flags", 32'({hit, hit_pulse}), 32'h0);
      reset = 1'b0;

      // ---- randomized, concurrent channels vs model ----
      do_reset();
      prescale = PW'($urandom_range(0, 3));
      mode     = 8'($urandom);
      target   = 16'($urandom);
      en       = 4'hF;
      for (int n = 0; n < 1500; n++) begin
         reset = ($urandom_range(0, 199) == 0);
         for (int i = 0; i < CH; i++) begin
            en[i]    = ($urandom_range(0, 63) != 0);
            clear[i] = ($urandom_range(0, 127) == 0);
            if ($urandom_range(0, 63) == 0) mode[2*i +: 2] = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 39) == 0) target[W*i +: W] = W'($urandom_range(0, 15));
         end
         if ($urandom_range(0, 99) == 0) prescale = PW'($urandom_range(0, 3));
         step();
         check("rnd_count", 32'(count),     32'(model_out[OW-1 -: W*CH]));
         check("rnd_hit",   32'(hit),       32'(model_out[2*CH-1 -: CH]));
         check("rnd_pulse", 32'(hit_pulse), 32'(model_out[CH-1:0]));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
